dma_axi_read_master: RTL and testbench
======================================

Name: dma_axi_read_master

Overview:
- AXI4-Full read master forming the source stage of the DMA datapath.
- Takes source address and byte length from the AXI-Lite control slave and issues INCR read bursts on the M00 interface.
- Pushes each returned beat into the bridge FIFO and stalls on FIFO full.
- Reports completion to the DMA top level. The write master consumes the FIFO downstream.

Parameters:
- C_M_AXI_BURST_LEN, 16, maximum beats per burst; must be a power of 2 in the range 1..256.
- C_M_AXI_ID_WIDTH, 1, width of ARID/RID.
- C_M_AXI_ADDR_WIDTH, 32, AXI address width.
- C_M_AXI_DATA_WIDTH, 32, AXI data width and FIFO word width; one beat is C_M_AXI_DATA_WIDTH/8 bytes (BPB).

Ports:
- M_AXI_ACLK  in  1  sole clock.
- M_AXI_ARESETN  in  1  reset, asynchronous assert, active-low.
- i_start  in  1  DMA start request from the control slave; the block acts on its rising edge.
- i_src_addr  in  32  source byte address; must be BPB-aligned.
- i_total_len  in  32  transfer length in bytes; must be a multiple of BPB.
- i_fifo_full  in  1  bridge FIFO full.
- o_fifo_push  out  1  FIFO write enable.
- o_r_data  out  DATA_WIDTH  FIFO write data.
- o_read_done  out  1  completion flag (level).
- o_error  out  1  sticky error flag.
- o_busy  out  1  transfer in progress.
- M_AXI_ARID  out  ID_WIDTH  read ID; constant 0.
- M_AXI_ARADDR  out  ADDR_WIDTH  burst start address.
- M_AXI_ARLEN  out  8  beats minus 1.
- M_AXI_ARSIZE  out  3  log2(BPB).
- M_AXI_ARBURST  out  2  constant 2'b01 (INCR).
- M_AXI_ARVALID  out  1  read address valid.
- M_AXI_ARREADY  in  1  read address ready.
- M_AXI_RID  in  ID_WIDTH  ignored.
- M_AXI_RDATA  in  DATA_WIDTH  read data.
- M_AXI_RRESP  in  2  read response.
- M_AXI_RLAST  in  1  last beat of burst.
- M_AXI_RVALID  in  1  read data valid.
- M_AXI_RREADY  out  1  read data ready.

Behaviour:
- Reset values:
  - State IDLE.
  - ARVALID=0, RREADY=0, o_fifo_push=0.
  - o_read_done=0, o_error=0, o_busy=0.
  - ARADDR=0, ARLEN=0, internal counters 0.
- Start detection:
  - i_start is registered; a start fires when i_start=1 and its registered copy=0.
  - The start is accepted only in IDLE or DONE; starts during a transfer are ignored.
- On an accepted start:
  - Latch addr = i_src_addr and remaining_beats = i_total_len / BPB (logical shift).
  - Clear o_read_done and o_error; set o_busy.
  - If remaining_beats == 0, go to DONE; otherwise go to ADDR.
- State ADDR:
  - burst_beats = min(remaining_beats, C_M_AXI_BURST_LEN, (4096 - addr[11:0]) / BPB). Bursts never cross a 4 KB boundary.
  - Drive ARADDR = addr and ARLEN = burst_beats - 1, and assert ARVALID.
  - ARADDR/ARLEN stay stable while ARVALID=1 && ARREADY=0.
  - On handshake: drop ARVALID; set beat_cnt = burst_beats; addr += burst_beats*BPB; remaining_beats -= burst_beats; go to DATA.
  - Only one burst is outstanding at a time.
- State DATA:
  - M_AXI_RREADY = !i_fifo_full (combinational).
  - o_fifo_push = RVALID & RREADY and o_r_data = RDATA (combinational passthrough), so there are zero cycles from beat to FIFO write.
  - On each accepted beat, beat_cnt decrements.
  - o_error sets if RRESP != 2'b00.
  - o_error sets if RLAST disagrees with (beat_cnt == 1).
  - At the counted last beat: go to ADDR if remaining_beats != 0, else go to DONE.
  - Burst termination uses beat_cnt; RLAST is used only for the mismatch check.
- State DONE:
  - o_read_done=1 and o_busy=0; both hold until the next accepted start.
  - RREADY=0 and ARVALID=0.
- Backpressure:
  - FIFO full at any point mid-burst deasserts RREADY in the same cycle. No push occurs, and no beat is lost or duplicated.
  - Full is safe to sample combinationally because the FIFO asserts full after the write that fills it.
- Simultaneous events: a start on the same cycle as the final beat is ignored, because the state is not yet DONE.
- Reset mid-operation:
  - Asynchronous return to IDLE with all outputs at reset values.
  - The in-flight AXI burst is abandoned; the interconnect is reset with the same signal.
- Arithmetic:
  - addr wraps modulo 2^ADDR_WIDTH.
  - remaining_beats is 32-bit.
  - 4 KB math uses addr[11:0] only.
- Unused outputs (AR lock/cache/prot/qos) are tied off at the top level, not in this block.

Test Plan:
- addr=0x1000, len=64, memory model ARREADY immediate, no stalls -> one AR with ARADDR=0x1000, ARLEN=15, ARSIZE=2; 16 pushes in order; o_read_done=1 one cycle after the last beat.
- addr=0x2000, len=100 -> two ARs: (0x2000, ARLEN=15) then (0x2040, ARLEN=8); 25 pushes; done=1; o_error=0.
- addr=0x0FF0, len=64 -> ARs (0x0FF0, ARLEN=3) then (0x1000, ARLEN=11); 16 pushes; no burst crosses 0x1000.
- len=64, i_fifo_full=1 for 5 cycles after beat 6 -> RREADY=0 and no push during the stall; all 16 data words arrive in the FIFO exactly once and in order.
- len=0 -> no ARVALID ever; o_read_done=1 within 2 cycles of the start edge.
- RRESP=2'b10 on beat 3 -> o_error=1 and the transfer completes. A second start clears o_error. ARESETN pulsed low mid-burst -> all outputs return to reset values immediately, and the next start runs a clean transfer.

Source files
------------

// File: rtl/dma_axi_read_master.sv
// ---------------------------------------------------------------------------
// dma_axi_read_master
//
// Source stage of the DMA datapath. Reads i_total_len bytes starting at
// i_src_addr over an AXI4 read channel using INCR bursts, and forwards every
// returned beat straight into the bridge FIFO.
//
// Ports
//   M_AXI_ACLK / M_AXI_ARESETN : clock, asynchronous active-low reset
//   i_start                    : start request, acted on at its rising edge
//   i_src_addr / i_total_len   : source byte address / length in bytes
//   i_fifo_full                : bridge FIFO full (backpressure)
//   o_fifo_push / o_r_data     : FIFO write enable / write data
//   o_read_done                : level, set when the transfer has finished
//   o_error                    : sticky, bad RRESP or RLAST out of place
//   o_busy                     : transfer in progress
//   M_AXI_AR* / M_AXI_R*       : AXI4 read address / read data channels
//
// Handshake rule used on every channel: a transfer happens on the rising
// clock edge where VALID and READY are both 1; VALID, once raised, holds
// its payload stable until that edge.
// ---------------------------------------------------------------------------
module dma_axi_read_master #(
  parameter int C_M_AXI_BURST_LEN   = 16,
  parameter int C_M_AXI_ID_WIDTH    = 1,
  parameter int C_M_AXI_ADDR_WIDTH  = 32,
  parameter int C_M_AXI_DATA_WIDTH  = 32
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESETN,
  input  logic                          i_start,
  input  logic [31:0]                   i_src_addr,
  input  logic [31:0]                   i_total_len,
  input  logic                          i_fifo_full,
  output logic                          o_fifo_push,
  output logic [C_M_AXI_DATA_WIDTH-1:0] o_r_data,
  output logic                          o_read_done,
  output logic                          o_error,
  output logic                          o_busy,
  output logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]                    M_AXI_ARLEN,
  output logic [2:0]                    M_AXI_ARSIZE,
  output logic [1:0]                    M_AXI_ARBURST,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RLAST,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  localparam int AW   = C_M_AXI_ADDR_WIDTH;
  localparam int BPB  = C_M_AXI_DATA_WIDTH / 8;
  localparam int SIZE = $clog2(BPB);
  localparam logic [12:0] MAX_BEATS = 13'(C_M_AXI_BURST_LEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            start_q;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     remaining_q, remaining_d;
  logic [8:0]      beat_cnt_q, beat_cnt_d;
  logic            arvalid_q, arvalid_d;
  logic [AW-1:0]   araddr_q, araddr_d;
  logic [7:0]      arlen_q, arlen_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic            busy_q, busy_d;

  logic            start_pulse;
  logic            beat_acc;
  logic [12:0]     bytes_to_4k;
  logic [12:0]     beats_to_4k;
  logic [8:0]      beat_limit;
  logic [8:0]      burst_beats;
  logic [8:0]      burst_now;
  logic [31:0]     start_beats;
  logic            unused_rid;

  // RID carries no information for a single-ID, single-outstanding master.
  assign unused_rid = ^M_AXI_RID;

  assign start_pulse = i_start & ~start_q;
  assign start_beats = i_total_len >> SIZE;

  // Burst size: the smallest of the beats left, the burst cap and the beats
  // that fit before the next 4 KB page. Only addr[11:0] matters here.
  always_comb begin
    bytes_to_4k = 13'h1000 - {1'b0, addr_q[11:0]};
    beats_to_4k = bytes_to_4k >> SIZE;
    if (beats_to_4k > MAX_BEATS) begin
      beat_limit = MAX_BEATS[8:0];
    end else begin
      beat_limit = beats_to_4k[8:0];
    end
    if (remaining_q < {23'd0, beat_limit}) begin
      burst_beats = remaining_q[8:0];
    end else begin
      burst_beats = beat_limit;
    end
  end

  // Beats of the burst currently on the AR channel (ARLEN is beats-1).
  assign burst_now = {1'b0, arlen_q} + 9'd1;

  // Read data goes straight to the FIFO; full is only raised after the write
  // that fills it, so gating RREADY with it in the same cycle is safe.
  assign M_AXI_RREADY = (state_q == S_DATA) && !i_fifo_full;
  assign beat_acc     = M_AXI_RVALID && M_AXI_RREADY;
  assign o_fifo_push  = beat_acc;
  assign o_r_data     = M_AXI_RDATA;

  assign M_AXI_ARID    = '0;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARLEN   = arlen_q;
  assign M_AXI_ARSIZE  = 3'(SIZE);
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARVALID = arvalid_q;

  assign o_read_done = done_q;
  assign o_error     = error_q;
  assign o_busy      = busy_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    beat_cnt_d  = beat_cnt_q;
    arvalid_d   = arvalid_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    done_d      = done_q;
    error_d     = error_q;
    busy_d      = busy_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_pulse) begin
          addr_d      = AW'(i_src_addr);
          remaining_d = start_beats;
          error_d     = 1'b0;
          if (start_beats == 32'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_ADDR;
            done_d  = 1'b0;
            busy_d  = 1'b1;
          end
        end
      end

      S_ADDR: begin
        // First cycle in ADDR loads the request; the registers then hold
        // steady until the slave takes it.
        if (!arvalid_q) begin
          arvalid_d = 1'b1;
          araddr_d  = addr_q;
          arlen_d   = 8'(burst_beats - 9'd1);
        end else if (M_AXI_ARREADY) begin
          arvalid_d   = 1'b0;
          beat_cnt_d  = burst_now;
          addr_d      = addr_q + (AW'(burst_now) << SIZE);
          remaining_d = remaining_q - {23'd0, burst_now};
          state_d     = S_DATA;
        end
      end

      S_DATA: begin
        if (beat_acc) begin
          beat_cnt_d = beat_cnt_q - 9'd1;
          if (M_AXI_RRESP != 2'b00) begin
            error_d = 1'b1;
          end
          // RLAST only cross-checks our own beat count; it never ends a burst.
          if (M_AXI_RLAST != (beat_cnt_q == 9'd1)) begin
            error_d = 1'b1;
          end
          if (beat_cnt_q == 9'd1) begin
            if (remaining_q != 32'd0) begin
              state_d = S_ADDR;
            end else begin
              state_d = S_DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      addr_q      <= '0;
      remaining_q <= '0;
      beat_cnt_q  <= '0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= i_start;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      beat_cnt_q  <= beat_cnt_d;
      arvalid_q   <= arvalid_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      done_q      <= done_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_dma_axi_read_master.sv
// ---------------------------------------------------------------------------
// tb_dma_axi_read_master
//
// Table of transfers driven through the read master against a small AXI
// read slave model. Expected AR requests and FIFO words are queued when a
// transfer is launched and popped as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_dma_axi_read_master;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        i_start;
  logic [31:0] i_src_addr;
  logic [31:0] i_total_len;
  logic        i_fifo_full;
  logic        o_fifo_push;
  logic [31:0] o_r_data;
  logic        o_read_done;
  logic        o_error;
  logic        o_busy;
  logic [0:0]  M_AXI_ARID;
  logic [31:0] M_AXI_ARADDR;
  logic [7:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [0:0]  M_AXI_RID;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RLAST;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;

  dma_axi_read_master dut (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESETN (rst_n),
    .i_start       (i_start),
    .i_src_addr    (i_src_addr),
    .i_total_len   (i_total_len),
    .i_fifo_full   (i_fifo_full),
    .o_fifo_push   (o_fifo_push),
    .o_r_data      (o_r_data),
    .o_read_done   (o_read_done),
    .o_error       (o_error),
    .o_busy        (o_busy),
    .M_AXI_ARID    (M_AXI_ARID),
    .M_AXI_ARADDR  (M_AXI_ARADDR),
    .M_AXI_ARLEN   (M_AXI_ARLEN),
    .M_AXI_ARSIZE  (M_AXI_ARSIZE),
    .M_AXI_ARBURST (M_AXI_ARBURST),
    .M_AXI_ARVALID (M_AXI_ARVALID),
    .M_AXI_ARREADY (M_AXI_ARREADY),
    .M_AXI_RID     (M_AXI_RID),
    .M_AXI_RDATA   (M_AXI_RDATA),
    .M_AXI_RRESP   (M_AXI_RRESP),
    .M_AXI_RLAST   (M_AXI_RLAST),
    .M_AXI_RVALID  (M_AXI_RVALID),
    .M_AXI_RREADY  (M_AXI_RREADY)
  );

  // ---------------- test table ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] len;
    int          stall_after;  // stall FIFO for 5 cycles after this push (0 = never)
    int          err_beat;     // 1-based beat answered with SLVERR (0 = none)
    bit          poke;         // pulse i_start mid-transfer
    int          n_ar;
    logic [7:0]  ar0_len;
    bit          exp_err;
  } tcase_t;

  tcase_t tbl[8];

  // ---------------- scoreboard ----------------
  logic [39:0] exp_ar_q[$];   // {araddr, arlen}
  logic [31:0] exp_q[$];      // FIFO words in order
  int n_cmp = 0;
  int n_bad = 0;

  int          stall_after;
  int          err_beat;
  int          stall_cnt;
  int          push_cnt;
  int          ar_cnt;
  int          beat_num;
  bit          r_active;
  logic [31:0] r_addr;
  int          r_left;
  bit          done_next;
  logic [7:0]  first_len;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'hC0DE_0000) + 32'd7;
  endfunction

  // ---------------- AXI read slave model ----------------
  // Drives at the falling edge, then (#1 later) predicts which handshakes the
  // next rising edge will complete and checks the DUT against the queues.
  initial begin
    logic [39:0] e;
    M_AXI_ARREADY = 1'b0;
    M_AXI_RVALID  = 1'b0;
    M_AXI_RDATA   = '0;
    M_AXI_RRESP   = 2'b00;
    M_AXI_RLAST   = 1'b0;
    M_AXI_RID     = '0;
    i_fifo_full   = 1'b0;
    r_active = 0; r_addr = '0; r_left = 0; stall_cnt = 0; done_next = 0;
    push_cnt = 0; ar_cnt = 0; beat_num = 0; stall_after = 0; err_beat = 0;
    first_len = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        r_active = 0; stall_cnt = 0; done_next = 0;
        M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0;
        i_fifo_full = 1'b0;
      end else begin
        if (done_next) begin
          chk("done_after_last", o_read_done, 1);
          done_next = 0;
        end
        i_fifo_full = (stall_cnt > 0);
        if (stall_cnt > 0) stall_cnt--;
        M_AXI_ARREADY = !r_active && ($urandom_range(0, 2) != 0);
        M_AXI_RVALID  = r_active;
        M_AXI_RDATA   = mem_word(r_addr);
        M_AXI_RLAST   = r_active && (r_left == 1);
        M_AXI_RRESP   = (r_active && (beat_num + 1 == err_beat)) ? 2'b10 : 2'b00;
        #1;
        if (i_fifo_full && r_active) begin
          chk("stall_rready", M_AXI_RREADY, 0);
          chk("stall_push", o_fifo_push, 0);
        end
        if (M_AXI_ARVALID && M_AXI_ARREADY) begin
          if (exp_ar_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL ar_extra: got AR addr %0h len %0d, expected none", M_AXI_ARADDR, M_AXI_ARLEN);
          end else begin
            e = exp_ar_q.pop_front();
            chk("araddr", M_AXI_ARADDR, e[39:8]);
            chk("arlen", M_AXI_ARLEN, e[7:0]);
            chk("arsize", M_AXI_ARSIZE, 3'd2);
            chk("arburst", M_AXI_ARBURST, 2'b01);
          end
          if (ar_cnt == 0) first_len = M_AXI_ARLEN;
          ar_cnt++;
          r_active = 1;
          r_addr   = M_AXI_ARADDR;
          r_left   = M_AXI_ARLEN + 1;
        end
        if (M_AXI_RVALID && M_AXI_RREADY) begin
          chk("push_on_beat", o_fifo_push, 1);
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL data_extra: got %0h, expected no more words", o_r_data);
          end else begin
            chk("fifo_data", o_r_data, exp_q.pop_front());
          end
          beat_num++;
          push_cnt++;
          r_addr = r_addr + 32'd4;
          r_left--;
          if (r_left == 0) begin
            r_active = 0;
            if (exp_ar_q.size() == 0) done_next = 1;
          end
          if (push_cnt == stall_after) stall_cnt = 5;
        end else begin
          chk("no_push", o_fifo_push, 0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic prep(input tcase_t tc);
    logic [31:0] a, rem, bl, b4k;
    exp_ar_q.delete();
    exp_q.delete();
    a   = tc.addr;
    rem = tc.len >> 2;
    while (rem != 0) begin
      bl  = (rem > 32'd16) ? 32'd16 : rem;
      b4k = (32'h1000 - {20'h0, a[11:0]}) >> 2;
      if (bl > b4k) bl = b4k;
      exp_ar_q.push_back({a, 8'(bl - 32'd1)});
      for (int k = 0; k < int'(bl); k++) exp_q.push_back(mem_word(a + 32'(4 * k)));
      a   = a + bl * 32'd4;
      rem = rem - bl;
    end
  endtask

  task automatic kick(input tcase_t tc);
    @(negedge clk);
    stall_after = tc.stall_after;
    err_beat    = tc.err_beat;
    push_cnt = 0; ar_cnt = 0; beat_num = 0; first_len = '0;
    i_src_addr  = tc.addr;
    i_total_len = tc.len;
    i_start     = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("start_err_clr", o_error, 0);
    chk("start_busy", o_busy, (tc.len != 0));
    chk("start_done", o_read_done, (tc.len == 0));
  endtask

  task automatic run_case(input tcase_t tc);
    int wait_n;
    bit poked;
    prep(tc);
    kick(tc);
    wait_n = 0;
    poked  = 0;
    while (!o_read_done && wait_n < 4000) begin
      @(negedge clk);
      wait_n++;
      if (i_start) begin
        i_start = 1'b0;
      end else if (tc.poke && !poked && push_cnt >= 3) begin
        i_start = 1'b1;
        poked   = 1;
      end
    end
    i_start = 1'b0;
    chk("done_seen", o_read_done, 1);
    repeat (3) @(negedge clk);
    chk("ar_count", ar_cnt, tc.n_ar);
    if (tc.n_ar > 0) chk("ar0_len", first_len, tc.ar0_len);
    chk("ar_left", exp_ar_q.size(), 0);
    chk("data_left", exp_q.size(), 0);
    chk("end_error", o_error, tc.exp_err);
    chk("end_busy", o_busy, 0);
    chk("end_done", o_read_done, 1);
    chk("end_arvalid", M_AXI_ARVALID, 0);
    chk("end_rready", M_AXI_RREADY, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_arvalid"}, M_AXI_ARVALID, 0);
    chk({tag, "_rready"}, M_AXI_RREADY, 0);
    chk({tag, "_push"}, o_fifo_push, 0);
    chk({tag, "_done"}, o_read_done, 0);
    chk({tag, "_error"}, o_error, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_araddr"}, M_AXI_ARADDR, 0);
    chk({tag, "_arlen"}, M_AXI_ARLEN, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    tcase_t rc;
    int     w;
    rst_n = 1'b0;
    i_start = 1'b0;
    i_src_addr = '0;
    i_total_len = '0;

    //           addr          len   stall err poke n_ar ar0  err
    tbl[0] = '{32'h0000_1000, 32'd64,   0, 0, 0,  1, 8'd15, 0};
    tbl[1] = '{32'h0000_2000, 32'd100,  0, 0, 0,  2, 8'd15, 0};
    tbl[2] = '{32'h0000_0FF0, 32'd64,   0, 0, 0,  2, 8'd3,  0};
    tbl[3] = '{32'h0000_4000, 32'd64,   6, 0, 0,  1, 8'd15, 0};
    tbl[4] = '{32'h0000_5000, 32'd0,    0, 0, 0,  0, 8'd0,  0};
    tbl[5] = '{32'h0000_6000, 32'd64,   0, 3, 0,  1, 8'd15, 1};
    tbl[6] = '{32'h0000_7000, 32'd64,   0, 0, 1,  1, 8'd15, 0};
    tbl[7] = '{32'h0000_8FC0, 32'd1024, 0, 0, 0, 16, 8'd15, 0};

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    #3 rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_case(tbl[i]);

    // Reset pulsed in the middle of a burst, then a clean transfer.
    rc = '{32'h0000_3000, 32'd64, 0, 0, 0, 1, 8'd15, 0};
    prep(rc);
    kick(rc);
    w = 0;
    while (push_cnt < 5 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("midreset_reached", (push_cnt >= 5), 1);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_vals("midreset");
    exp_ar_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    run_case('{32'h0000_A000, 32'd48, 0, 0, 0, 1, 8'd11, 0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Backstop in case the DUT wedges somewhere no bounded wait covers.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
